// File: rtl/svpwm_pkg.sv
// Shared types and constants for the SVPWM duty generator.
package svpwm_pkg;

    // sqrt(3)/2 in Q15
    localparam logic signed [15:0] K_SQRT3_2 = 16'sd28378;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PHASE,
        ST_OFFSET,
        ST_DUTY,
        ST_DONE
    } state_t;

    typedef logic [2:0] sector_t;

    // Map N = 4*C + 2*B + A onto the SVPWM sector number; degenerate codes land in sector 1.
    function automatic sector_t sector_from_n(input logic [2:0] n);
        sector_t s;
        case (n)
            3'd3:    s = 3'd1;
            3'd1:    s = 3'd2;
            3'd5:    s = 3'd3;
            3'd4:    s = 3'd4;
            3'd6:    s = 3'd5;
            3'd2:    s = 3'd6;
            default: s = 3'd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/svpwm_sector_decode.sv
// Combinational sector decode from the three reference projections.
module svpwm_sector_decode
    import svpwm_pkg::*;
(
    input  logic signed [17:0] vref1,
    input  logic signed [17:0] vref2,
    input  logic signed [17:0] vref3,
    output logic [2:0]         sector
);

    logic [2:0] n;

    // A/B/C are "non-negative" flags, i.e. the inverted sign bits.
    assign n      = {~vref3[17], ~vref2[17], ~vref1[17]};
    assign sector = sector_from_n(n);

endmodule

// File: rtl/svpwm_duty_gen.sv
// SVPWM stage: (alpha, beta) -> sector and min-max-injected compare values.
module svpwm_duty_gen
    import svpwm_pkg::*;
#(
    parameter int PERIOD = 2000,
    parameter int DUTY_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] alpha,
    input  logic signed [15:0] beta,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         sector,
    output logic [DUTY_W-1:0]  duty_a,
    output logic [DUTY_W-1:0]  duty_b,
    output logic [DUTY_W-1:0]  duty_c
);

    localparam logic signed [31:0] PERIOD_S = 32'(PERIOD);
    localparam logic signed [31:0] HALF_S   = 32'(PERIOD / 2);

    // Centre the shifted phase voltage on PERIOD/2 and clamp into the counter range.
    function automatic logic [DUTY_W-1:0] scale_clamp(input logic signed [17:0] vx,
                                                       input logic signed [18:0] voff);
        logic signed [19:0]   sum;
        logic signed [31:0]   prod;
        logic signed [31:0]   duty;
        logic [DUTY_W-1:0]    res;
        sum  = 20'(vx) + 20'(voff);
        prod = 32'(sum) * PERIOD_S;
        duty = HALF_S + (prod >>> 16);
        if (duty < 0)
            res = '0;
        else if (duty > PERIOD_S)
            res = DUTY_W'(PERIOD);
        else
            res = DUTY_W'(duty);
        return res;
    endfunction

    state_t             state_q, state_d;
    logic signed [15:0] alpha_q, alpha_d;
    logic signed [15:0] beta_q, beta_d;
    logic signed [17:0] v_q [3];
    logic signed [17:0] v_d [3];
    logic signed [17:0] vref_q [3];
    logic signed [17:0] vref_d [3];
    logic signed [18:0] voff_q, voff_d;
    logic [2:0]         sec_int_q, sec_int_d;
    logic [2:0]         sector_q, sector_d;
    logic [DUTY_W-1:0]  duty_q [3];
    logic [DUTY_W-1:0]  duty_d [3];

    logic signed [31:0] kb, ka;
    logic signed [17:0] a18, b18, q18, p18;
    logic signed [17:0] vmax, vmin;
    logic signed [18:0] vsum;
    logic [2:0]         dec_sector;
    logic [DUTY_W-1:0]  duty_calc [3];

    // Rotation products of the captured sample, truncated to the 18-bit working width.
    always_comb begin
        kb  = 32'(K_SQRT3_2) * 32'(beta_q);
        ka  = 32'(K_SQRT3_2) * 32'(alpha_q);
        q18 = 18'(kb >>> 15);
        p18 = 18'(ka >>> 15);
        a18 = 18'(alpha_q);
        b18 = 18'(beta_q);
    end

    // Extremes of the three phase voltages for zero-sequence injection.
    always_comb begin
        vmax = v_q[0];
        vmin = v_q[0];
        for (int i = 1; i < 3; i++) begin
            if (v_q[i] > vmax) vmax = v_q[i];
            if (v_q[i] < vmin) vmin = v_q[i];
        end
        vsum = 19'(vmax) + 19'(vmin);
    end

    svpwm_sector_decode u_sector_decode (
        .vref1  (vref_q[0]),
        .vref2  (vref_q[1]),
        .vref3  (vref_q[2]),
        .sector (dec_sector)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            assign duty_calc[gi] = scale_clamp(v_q[gi], voff_q);
        end
    endgenerate

    // Next-state and handshake decode; in_ready is pure state decode gated by reset.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~rst_n;
                if (in_valid) state_d = ST_PHASE;
            end
            ST_PHASE:  state_d = ST_OFFSET;
            ST_OFFSET: state_d = ST_DUTY;
            ST_DUTY:   state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath register updates, one pipeline step per state.
    always_comb begin
        alpha_d   = alpha_q;
        beta_d    = beta_q;
        v_d       = v_q;
        vref_d    = vref_q;
        voff_d    = voff_q;
        sec_int_d = sec_int_q;
        sector_d  = sector_q;
        duty_d    = duty_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alpha_d = alpha;
                    beta_d  = beta;
                end
            end
            ST_PHASE: begin
                v_d[0]    = a18;
                v_d[1]    = -(a18 >>> 1) + q18;
                v_d[2]    = -(a18 >>> 1) - q18;
                vref_d[0] = b18;
                vref_d[1] = p18 - (b18 >>> 1);
                vref_d[2] = -p18 - (b18 >>> 1);
            end
            ST_OFFSET: begin
                voff_d    = -(vsum >>> 1);
                sec_int_d = dec_sector;
            end
            ST_DUTY: begin
                sector_d = sec_int_q;
                duty_d   = duty_calc;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset discards any sample in flight.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            alpha_q   <= '0;
            beta_q    <= '0;
            voff_q    <= '0;
            sec_int_q <= '0;
            sector_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                v_q[i]    <= '0;
                vref_q[i] <= '0;
                duty_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            alpha_q   <= alpha_d;
            beta_q    <= beta_d;
            voff_q    <= voff_d;
            sec_int_q <= sec_int_d;
            sector_q  <= sector_d;
            for (int i = 0; i < 3; i++) begin
                v_q[i]    <= v_d[i];
                vref_q[i] <= vref_d[i];
                duty_q[i] <= duty_d[i];
            end
        end
    end

    assign sector = sector_q;
    assign duty_a = duty_q[0];
    assign duty_b = duty_q[1];
    assign duty_c = duty_q[2];

endmodule

// File: doc/svpwm_duty_gen.md
# svpwm_duty_gen

Space-vector modulation stage directly downstream of the Clarke transform. Accepts one (alpha, beta) stationary-frame voltage sample per handshake and computes the SVPWM sector and three phase compare values using min-max zero-sequence injection. The compare values feed the centre-aligned PWM counter for phases A/B/C.

## Interface

Parameters:
- PERIOD, 2000: PWM half-carrier period in counts; compare range is 0..PERIOD.
- DUTY_W, 12: compare value width; must satisfy 2^DUTY_W > PERIOD.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset. The name follows codebase convention; the polarity is high.
- in_valid  in  1  alpha/beta valid.
- in_ready  out  1  block can accept a sample.
- alpha  in  16  signed Q1.15 stationary-frame alpha.
- beta  in  16  signed Q1.15 stationary-frame beta.
- out_valid  out  1  results valid, held until consumed.
- out_ready  in  1  downstream accepts results.
- sector  out  3  SVPWM sector 1..6; 0 only out of reset.
- duty_a / duty_b / duty_c  out  DUTY_W each  compare values 0..PERIOD.

## Operation

- FSM states: IDLE, PHASE, OFFSET, DUTY, DONE.
  - IDLE: in_ready=1. On in_valid, register alpha/beta and go to PHASE.
  - PHASE: K=28378 (√3/2 in Q15). Q=(K·beta)>>>15, P=(K·alpha)>>>15.
    - va=alpha; vb=-(alpha>>>1)+Q; vc=-(alpha>>>1)-Q.
    - Vref1=beta; Vref2=P-(beta>>>1); Vref3=-P-(beta>>>1).
    - All values 18-bit signed, registered. Go to OFFSET.
  - OFFSET: voff=-((max(va,vb,vc)+min(va,vb,vc))>>>1), 19-bit signed.
    - Sector from N=4·C+2·B+A, with A=(Vref1≥0), B=(Vref2≥0), C=(Vref3≥0).
    - Map N: 3→1, 1→2, 5→3, 4→4, 6→5, 2→6, 0→1, 7→1.
    - Go to DUTY.
  - DUTY: duty_x = PERIOD/2 + (((vx+voff)·PERIOD)>>>16).
    - Use a 32-bit signed product; >>> floors toward −∞.
    - Clamp to [0, PERIOD]. Register the outputs and sector. Go to DONE.
  - DONE: out_valid=1. Outputs stay stable while out_ready=0. On out_ready, go to IDLE.
- in_ready=0 in every state except IDLE. Samples offered outside IDLE are not captured and must be held by upstream.
- Reset: state IDLE, out_valid=0, sector=0, duty_a/b/c=0, internal registers 0. in_ready=0 while rst_n=1.
- Reset asserted mid-computation or in DONE discards the sample. No out_valid for it.
- Outputs keep their last values after consumption until the next DUTY update.

## Timing

- Acceptance edge E0 (in_valid & in_ready). Then PHASE→E1, OFFSET→E2, DUTY→E3. out_valid high after E3.
- Latency: 3 cycles from acceptance to out_valid.
- With out_ready=1 at E4: out_valid low and in_ready high after E4. Earliest next acceptance is E5, giving a 5-cycle minimum initiation interval.
- No combinational path from in_valid/out_ready to any output except in_ready (state decode only).
- sector and duty_x change only on the DUTY edge.

## Structure

- svpwm_pkg holds:
  - localparam K_SQRT3_2=16'sd28378.
  - State enum typedef.
  - The sector type, 3-bit logic.
  - The N→sector mapping function.
- Sub-module svpwm_sector_decode: combinational Vref1/2/3 → sector. It is instantiated in OFFSET and is unit-testable alone.
- Clamp and scaling stay inline in svpwm_duty_gen.

## Test plan

- Reset → out_valid=0, sector=0, duty_a/b/c=0, in_ready=0. After release, in_ready=1.
- alpha=0, beta=0 → sector=1, duty_a=duty_b=duty_c=1000, out_valid 3 cycles after accept.
- alpha=16384, beta=0 → sector=1, duty_a=1375, duty_b=625, duty_c=625.
- alpha=0, beta=16384 → sector=2, duty_a=1000, duty_b=1433, duty_c=566.
- alpha=-32768, beta=-32768 → sector=4, duty_a=0 (clamped), duty_b=450, duty_c=2000 (clamped).
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0, a second in_valid is not captured.
  - Release out_ready: next sample is accepted 1 cycle later.
  - Assert rst_n during OFFSET: no out_valid, outputs return to 0.
